// File: rtl/seg7_scan_rx.sv
// Scanned seven-segment receiver: filters each digit's strobes, decodes the
// active-low patterns and publishes a whole 8-digit frame at a time.
module seg7_scan_rx #(
    parameter int unsigned STABLE = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [6:0]  iSEG,
    input  logic [7:0]  iSEL,
    input  logic        iSTB,
    output logic [31:0] oDIG,
    output logic [7:0]  oBLANK,
    output logic [7:0]  oERR,
    output logic        oFRAME,
    output logic        oSEL_ERR
);

    localparam int unsigned NDIG = 8;
    localparam int unsigned SEGW = 7;
    localparam int unsigned CNTW = 4;
    localparam logic [CNTW-1:0] STABLE_C  = CNTW'(STABLE);
    localparam logic [SEGW-1:0] BLANK_PAT = 7'h7F;

    typedef enum logic {COLLECT, PUBLISH} state_t;

    state_t state, stateNext;

    logic [NDIG-1:0][SEGW-1:0] lastPat, lastPatNext;
    logic [NDIG-1:0][CNTW-1:0] cnt, cntNext;
    logic [NDIG-1:0]           qualMask;
    logic [NDIG-1:0]           collected, collectedNext;
    logic [31:0]               shDig;
    logic [NDIG-1:0]           shBlank, shErr;
    logic                      selOneHot, accept, publish;
    logic [3:0]                decNib;
    logic                      decBlank, decErr;

    // Pattern -> {err, blank, nibble}; unknown patterns read as nibble 0 with err.
    function automatic logic [5:0] decode(input logic [SEGW-1:0] seg);
        logic [5:0] r;
        case (seg)
            7'h40: r = {2'b00, 4'h0};
            7'h79: r = {2'b00, 4'h1};
            7'h24: r = {2'b00, 4'h2};
            7'h30: r = {2'b00, 4'h3};
            7'h19: r = {2'b00, 4'h4};
            7'h12: r = {2'b00, 4'h5};
            7'h02: r = {2'b00, 4'h6};
            7'h78: r = {2'b00, 4'h7};
            7'h00: r = {2'b00, 4'h8};
            7'h10: r = {2'b00, 4'h9};
            7'h08: r = {2'b00, 4'hA};
            7'h03: r = {2'b00, 4'hB};
            7'h46: r = {2'b00, 4'hC};
            7'h21: r = {2'b00, 4'hD};
            7'h06: r = {2'b00, 4'hE};
            7'h0E: r = {2'b00, 4'hF};
            BLANK_PAT: r = {2'b01, 4'h0};
            default: r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    assign selOneHot = $onehot(iSEL);
    assign accept    = iSTB & selOneHot;
    assign {decErr, decBlank, decNib} = decode(iSEG);

    // Per-digit stability counters; a digit qualifies when its run reaches STABLE.
    always_comb begin
        lastPatNext = lastPat;
        cntNext     = cnt;
        qualMask    = '0;
        for (int n = 0; n < NDIG; n++) begin
            if (accept && iSEL[n]) begin
                if (iSEG == lastPat[n]) begin
                    cntNext[n] = (cnt[n] >= STABLE_C) ? STABLE_C : cnt[n] + CNTW'(1);
                end else begin
                    lastPatNext[n] = iSEG;
                    cntNext[n]     = CNTW'(1);
                end
                qualMask[n] = (cntNext[n] == STABLE_C);
            end
        end
    end

    // Frame assembly next-state; a bit set during PUBLISH belongs to the next frame.
    always_comb begin
        stateNext     = state;
        collectedNext = collected;
        publish       = 1'b0;
        case (state)
            COLLECT: begin
                collectedNext = collected | qualMask;
                if (collectedNext == '1) stateNext = PUBLISH;
            end
            PUBLISH: begin
                publish       = 1'b1;
                collectedNext = qualMask;
                stateNext     = COLLECT;
            end
            default: stateNext = COLLECT;
        endcase
    end

    // FSM state and collected-digit mask.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= COLLECT;
            collected <= '0;
        end else begin
            state     <= stateNext;
            collected <= collectedNext;
        end
    end

    // Last-seen pattern and run length per digit.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            lastPat <= {NDIG{BLANK_PAT}};
            cnt     <= '0;
        end else begin
            lastPat <= lastPatNext;
            cnt     <= cntNext;
        end
    end

    // Shadow copy of the latest qualified decode for each digit.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shDig   <= '0;
            shBlank <= '0;
            shErr   <= '0;
        end else begin
            for (int n = 0; n < NDIG; n++) begin
                if (qualMask[n]) begin
                    shDig[4*n +: 4] <= decNib;
                    shBlank[n]      <= decBlank;
                    shErr[n]        <= decErr;
                end
            end
        end
    end

    // Published outputs and status pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDIG     <= '0;
            oBLANK   <= '1;
            oERR     <= '0;
            oFRAME   <= 1'b0;
            oSEL_ERR <= 1'b0;
        end else begin
            oFRAME   <= publish;
            oSEL_ERR <= iSTB & ~selOneHot;
            if (publish) begin
                oDIG   <= shDig;
                oBLANK <= shBlank;
                oERR   <= shErr;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Scoreboard bench for seg7_scan_rx: a reference model turns each issued strobe
// into expected frames / select-error pulses; a monitor pops and compares them.
module tb_seg7_scan_rx;

    localparam int unsigned STABLE = 2;

    logic        iCLK = 1'b0;
    logic        iRST, iSTB;
    logic [6:0]  iSEG;
    logic [7:0]  iSEL;
    logic [31:0] oDIG;
    logic [7:0]  oBLANK, oERR;
    logic        oFRAME, oSEL_ERR;

    seg7_scan_rx #(.STABLE(STABLE)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSEG(iSEG), .iSEL(iSEL), .iSTB(iSTB),
        .oDIG(oDIG), .oBLANK(oBLANK), .oERR(oERR), .oFRAME(oFRAME), .oSEL_ERR(oSEL_ERR)
    );

    always #5 iCLK = ~iCLK;

    // Edge counter: during the cycle after edge E it reads E.
    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] dig;
        logic [7:0]  blank;
        logic [7:0]  err;
    } frame_t;

    frame_t frameQ[$];
    int     selQ[$];
    int     nTests = 0;
    int     nFail  = 0;

    logic [6:0] segTab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [6:0]  mLast[8];
    int unsigned mRun[8];
    logic [3:0]  mNib[8];
    bit          mBlank[8], mErr[8], mColl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mLast[i] = 7'h7F; mRun[i] = 0; mNib[i] = 4'h0;
            mBlank[i] = 1'b0; mErr[i] = 1'b0; mColl[i] = 1'b0;
        end
    endtask

    task automatic modelStrobe(input logic [6:0] seg, input logic [7:0] sel);
        int  d;
        bit  all;
        frame_t f;
        if ($countones(sel) != 1) begin
            selQ.push_back(cyc);
            return;
        end
        d = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) d = i;
        if (seg == mLast[d]) mRun[d] = (mRun[d] + 1 > STABLE) ? STABLE : mRun[d] + 1;
        else begin
            mLast[d] = seg;
            mRun[d]  = 1;
        end
        if (mRun[d] == STABLE) begin
            mNib[d]   = 4'h0;
            mBlank[d] = (seg == 7'h7F);
            mErr[d]   = !mBlank[d];
            for (int k = 0; k < 16; k++) begin
                if (segTab[k] == seg) begin
                    mNib[d] = 4'(k);
                    mErr[d] = 1'b0;
                end
            end
            mColl[d] = 1'b1;
        end
        all = 1'b1;
        for (int i = 0; i < 8; i++) all &= mColl[i];
        if (all) begin
            f.cyc = cyc + 1;
            for (int i = 0; i < 8; i++) begin
                f.dig[4*i +: 4] = mNib[i];
                f.blank[i]      = mBlank[i];
                f.err[i]        = mErr[i];
                mColl[i]        = 1'b0;
            end
            frameQ.push_back(f);
        end
    endtask

    // One clock of stimulus; the model sees the strobe after the sampling edge.
    task automatic step(input bit stb, input logic [6:0] seg, input logic [7:0] sel);
        iSTB = stb; iSEG = seg; iSEL = sel;
        @(posedge iCLK);
        #1;
        if (stb) modelStrobe(seg, sel);
        iSTB = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'h7F, 8'h00);
    endtask

    task automatic doReset();
        iRST = 1'b1;
        step(1'b0, 7'h7F, 8'h00);
        iRST = 1'b0;
        modelReset();
    endtask

    task automatic showDigit(input int d, input logic [6:0] seg, input int reps);
        for (int r = 0; r < reps; r++) step(1'b1, seg, 8'(1) << d);
    endtask

    task automatic showValue(input logic [31:0] v, input int reps);
        for (int d = 0; d < 8; d++) showDigit(d, segTab[v[4*d +: 4]], reps);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_dig"},   oDIG, 32'h0);
        check({tag, "_blank"}, 32'(oBLANK), 32'hFF);
        check({tag, "_err"},   32'(oERR), 32'h0);
        check({tag, "_frame"}, 32'(oFRAME), 32'h0);
    endtask

    function automatic logic [6:0] pickPat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) return segTab[$urandom_range(0, 15)];
        if (r < 85) return 7'h7F;
        return 7'($urandom);
    endfunction

    // Monitor: compares every published frame and select-error pulse to the queue.
    always @(negedge iCLK) begin
        frame_t f;
        while (frameQ.size() != 0 && frameQ[0].cyc < cyc) begin
            f = frameQ.pop_front();
            nTests++; nFail++;
            $display("FAIL frame_missing: no oFRAME at cycle %0d, expected dig %h", f.cyc, f.dig);
        end
        while (selQ.size() != 0 && selQ[0] < cyc) begin
            nTests++; nFail++;
            $display("FAIL selerr_missing: no oSEL_ERR at cycle %0d", selQ.pop_front());
        end
        if (oFRAME === 1'b1) begin
            if (frameQ.size() == 0) begin
                nTests++; nFail++;
                $display("FAIL frame_unexpected: oFRAME at cycle %0d, dig %h", cyc, oDIG);
            end else begin
                f = frameQ.pop_front();
                check("frame_cycle", 32'(cyc), 32'(f.cyc));
                check("frame_dig",   oDIG, f.dig);
                check("frame_blank", 32'(oBLANK), 32'(f.blank));
                check("frame_err",   32'(oERR), 32'(f.err));
            end
        end
        if (oSEL_ERR === 1'b1) begin
            if (selQ.size() == 0) begin
                nTests++; nFail++;
                $display("FAIL selerr_unexpected: oSEL_ERR at cycle %0d", cyc);
            end else begin
                check("selerr_cycle", 32'(cyc), 32'(selQ.pop_front()));
            end
        end
    end

    initial begin
        logic [6:0] cur[8];
        logic [7:0] badSel;
        int a, b, r, d;

        iRST = 1'b1; iSTB = 1'b0; iSEG = 7'h7F; iSEL = 8'h00;
        modelReset();
        doReset();
        idle(10);
        checkResetState("reset");

        // Full frame 0x1234ABCD
        showValue(32'h1234ABCD, 2);
        idle(3);

        // Upper four digits blank, lower show 0x00F0
        showDigit(0, segTab[0], 2);
        showDigit(1, segTab[15], 2);
        showDigit(2, segTab[0], 2);
        showDigit(3, segTab[0], 2);
        for (int i = 4; i < 8; i++) showDigit(i, 7'h7F, 2);
        idle(3);

        // Illegal pattern on digit 2
        for (int i = 0; i < 8; i++) begin
            if (i == 2) showDigit(i, 7'h55, 2);
            else        showDigit(i, segTab[8 - i], 2);
        end
        idle(3);

        // Glitch on the final digit: 40,79,40 then 40
        for (int i = 1; i < 8; i++) showDigit(i, segTab[i], 2);
        step(1'b1, 7'h40, 8'h01);
        step(1'b1, 7'h79, 8'h01);
        step(1'b1, 7'h40, 8'h01);
        idle(2);
        step(1'b1, 7'h40, 8'h01);
        idle(3);

        // Bad selects in the middle of a frame
        for (int i = 0; i < 4; i++) showDigit(i, segTab[i + 4], 2);
        step(1'b1, 7'h24, 8'h03);
        step(1'b1, 7'h24, 8'h00);
        for (int i = 4; i < 8; i++) showDigit(i, segTab[i + 4], 2);
        idle(3);

        // Reset after 5 digits collected, then one full frame
        for (int i = 0; i < 5; i++) showDigit(i, segTab[15 - i], 2);
        doReset();
        checkResetState("midreset");
        showValue(32'hFEDC5678, 2);
        idle(3);

        // Randomized scanning with glitches, gaps and bad selects
        for (int i = 0; i < 8; i++) cur[i] = segTab[i];
        for (int s = 0; s < 1500; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                a = int'($urandom_range(0, 7));
                b = (a + int'($urandom_range(1, 7))) % 8;
                badSel = ($urandom_range(0, 1) == 0) ? 8'h00 : ((8'(1) << a) | (8'(1) << b));
                step(1'b1, pickPat(), badSel);
            end else if (r < 14) begin
                idle(1);
            end else begin
                d = int'($urandom_range(0, 7));
                if ($urandom_range(0, 99) < 25) cur[d] = pickPat();
                step(1'b1, cur[d], 8'(1) << d);
            end
        end
        idle(5);

        check("frames_drained", 32'(frameQ.size()), 32'h0);
        check("selerr_drained", 32'(selQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
